// File: rtl/diag_serial_pkg.sv
// ============================================================================
//  Module   : diag_serial_pkg
//  Purpose  : Shared widths, entry type and packing helper for the AFC
//             diagnostics serial receiver (diag_serial_rx, diag_rx_fifo).
//  Contents : DIAG_BYTE_W   - payload byte width
//             DIAG_ENTRY_W  - FIFO entry width, {first, data}
//             DIAG_BITCNT_W - bit-within-byte counter width
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package diag_serial_pkg;

   localparam int DIAG_BYTE_W   = 8;
   localparam int DIAG_ENTRY_W  = DIAG_BYTE_W + 1;
   localparam int DIAG_BITCNT_W = 3;

   typedef logic [DIAG_ENTRY_W-1:0] diag_entry_t;

   // FIFO entry layout: start-of-frame flag in the MSB, byte below it.
   function automatic diag_entry_t diag_pack(input logic                   first,
                                             input logic [DIAG_BYTE_W-1:0] data);
      return {first, data};
   endfunction

endpackage

`default_nettype wire

// File: rtl/diag_rx_fifo.sv
// ============================================================================
//  Module   : diag_rx_fifo
//  Purpose  : Small synchronous FIFO for received diagnostic bytes.
//             Push while full is accepted only when a pop happens in the
//             same cycle; a pop on empty is ignored.
//  Ports    : clk, rst (async, active-high)
//             i_push, i_wdata  - write request and data
//             i_pop            - read request (head advances)
//             o_rdata          - entry at the head
//             o_full, o_empty  - occupancy flags
//  Params   : WIDTH (entry width), DEPTH (power of 2, >= 2)
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module diag_rx_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty
);

   localparam int c_ADDR_W = $clog2(DEPTH);

   logic [WIDTH-1:0]  r_mem [DEPTH];
   // One extra pointer bit tells a full FIFO from an empty one.
   logic [c_ADDR_W:0] r_wr_ptr;
   logic [c_ADDR_W:0] r_rd_ptr;
   logic              w_do_push;
   logic              w_do_pop;

   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[c_ADDR_W] != r_rd_ptr[c_ADDR_W]) &&
                      (r_wr_ptr[c_ADDR_W-1:0] == r_rd_ptr[c_ADDR_W-1:0]);
   assign w_do_pop  = i_pop & ~o_empty;
   // A pop frees the head slot in the same cycle, so push-at-full is legal then.
   assign w_do_push = i_push & (~o_full | w_do_pop);
   assign o_rdata   = r_mem[r_rd_ptr[c_ADDR_W-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr[c_ADDR_W-1:0]] <= i_wdata;
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/diag_serial_rx.sv
// ============================================================================
//  Module   : diag_serial_rx
//  Purpose  : Serial-to-parallel receiver for the AFC diagnostics link.
//             Synchronises sck/cs_n/sdi into CLK, assembles MSB-first bytes
//             and queues them for a valid/ready consumer.
//  Ports    : CLK, rst (async, active-high)
//             sck, cs_n, sdi      - asynchronous serial inputs
//             m_data, m_first     - head byte and its start-of-frame flag
//             m_valid, m_ready    - consumer handshake
//             frame_err           - pulse: frame closed mid-byte
//             ovf, ovf_clr        - sticky drop flag and its clear
//             frame_len, frame_done - only with DIAG_SERIAL_RX_FRMCNT_EN
//  Config   : `define DIAG_SERIAL_RX_FRMCNT_EN adds the per-frame byte count.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module diag_serial_rx
   import diag_serial_pkg::*;
#(
   parameter int FIFO_DEPTH  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   CLK,
   input  logic                   rst,
   input  logic                   sck,
   input  logic                   cs_n,
   input  logic                   sdi,
   output logic [DIAG_BYTE_W-1:0] m_data,
   output logic                   m_first,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic                   frame_err,
   output logic                   ovf,
   input  logic                   ovf_clr
`ifdef DIAG_SERIAL_RX_FRMCNT_EN
  ,output logic [7:0]             frame_len,
   output logic                   frame_done
`endif
);

   logic [SYNC_STAGES-1:0]   r_sck_sync;
   logic [SYNC_STAGES-1:0]   r_cs_sync;
   logic [SYNC_STAGES-1:0]   r_sdi_sync;
   logic                     r_sck_hist;
   logic                     r_cs_hist;

   logic                     w_sck_s;
   logic                     w_cs_s;
   logic                     w_sdi_s;
   logic                     w_sck_rise;
   logic                     w_cs_fall;
   logic                     w_cs_rise;
   logic                     w_shift;
   logic                     w_last_bit;

   // Only the first seven bits are stored; the eighth goes straight into
   // the push register together with them.
   logic [DIAG_BYTE_W-2:0]   r_sr;
   logic [DIAG_BITCNT_W-1:0] r_bit_cnt;
   logic                     r_sof;
   // Set by a cs_n fall, cleared by a cs_n rise or reset: a frame that was
   // already open when reset released is ignored until it is re-opened.
   logic                     r_armed;
   logic                     r_push;
   diag_entry_t              r_push_data;
   logic                     r_frame_err;
   logic                     r_ovf;

   diag_entry_t              w_head;
   logic                     w_full;
   logic                     w_empty;
   logic                     w_pop;
   logic                     w_ovf_set;

   // ------------------------------------------------------------------
   // Synchronisers and edge detection
   // ------------------------------------------------------------------
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         r_sck_sync <= '0;
         r_cs_sync  <= '0;
         r_sdi_sync <= '0;
         r_sck_hist <= 1'b0;
         r_cs_hist  <= 1'b0;
      end else begin
         r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], sck};
         r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0],  cs_n};
         r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], sdi};
         r_sck_hist <= w_sck_s;
         r_cs_hist  <= w_cs_s;
      end
   end

   assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
   assign w_cs_s     = r_cs_sync[SYNC_STAGES-1];
   assign w_sdi_s    = r_sdi_sync[SYNC_STAGES-1];
   assign w_sck_rise = w_sck_s & ~r_sck_hist;
   assign w_cs_fall  = ~w_cs_s & r_cs_hist;
   assign w_cs_rise  = w_cs_s & ~r_cs_hist;
   assign w_shift    = w_sck_rise & ~w_cs_s & r_armed;
   assign w_last_bit = (r_bit_cnt == {DIAG_BITCNT_W{1'b1}});

   // ------------------------------------------------------------------
   // Shifter, bit counter, start-of-frame and frame-error logic
   // ------------------------------------------------------------------
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         r_sr        <= '0;
         r_bit_cnt   <= '0;
         r_sof       <= 1'b0;
         r_armed     <= 1'b0;
         r_push      <= 1'b0;
         r_push_data <= '0;
         r_frame_err <= 1'b0;
      end else begin
         r_push      <= 1'b0;
         r_frame_err <= 1'b0;
         if (w_cs_fall) begin
            r_bit_cnt <= '0;
            r_sof     <= 1'b1;
            r_armed   <= 1'b1;
         end else if (w_cs_rise) begin
            r_frame_err <= r_armed & (r_bit_cnt != '0);
            r_bit_cnt   <= '0;
            r_armed     <= 1'b0;
         end else if (w_shift) begin
            r_sr <= {r_sr[DIAG_BYTE_W-3:0], w_sdi_s};
            if (w_last_bit) begin
               r_push      <= 1'b1;
               r_push_data <= diag_pack(r_sof, {r_sr, w_sdi_s});
               r_bit_cnt   <= '0;
               r_sof       <= 1'b0;
            end else begin
               r_bit_cnt <= r_bit_cnt + 1'b1;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Byte FIFO and overflow flag
   // ------------------------------------------------------------------
   diag_rx_fifo #(
      .WIDTH (DIAG_ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (CLK),
      .rst     (rst),
      .i_push  (r_push),
      .i_wdata (r_push_data),
      .i_pop   (w_pop),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign w_pop     = ~w_empty & m_ready;
   assign w_ovf_set = r_push & w_full & ~w_pop;

   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         r_ovf <= 1'b0;
      end else begin
         // Set wins over a simultaneous clear.
         r_ovf <= w_ovf_set | (r_ovf & ~ovf_clr);
      end
   end

   assign m_valid   = ~w_empty;
   assign m_first   = w_head[DIAG_BYTE_W];
   assign m_data    = w_head[DIAG_BYTE_W-1:0];
   assign frame_err = r_frame_err;
   assign ovf       = r_ovf;

`ifdef DIAG_SERIAL_RX_FRMCNT_EN
   // ------------------------------------------------------------------
   // Per-frame byte counter
   // ------------------------------------------------------------------
   logic [7:0] r_byte_cnt;
   logic [7:0] r_frame_len;
   logic       r_frame_done;

   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         r_byte_cnt   <= '0;
         r_frame_len  <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         if (w_cs_fall) begin
            r_byte_cnt <= '0;
         end else if (w_cs_rise) begin
            // A rise without a matching fall (frame open across reset) is not a frame.
            r_frame_done <= r_armed;
            if (r_armed) begin
               r_frame_len <= r_byte_cnt;
            end
         end else if (w_shift && w_last_bit && (r_byte_cnt != 8'hFF)) begin
            r_byte_cnt <= r_byte_cnt + 1'b1;
         end
      end
   end

   assign frame_len  = r_frame_len;
   assign frame_done = r_frame_done;
`endif

endmodule

`default_nettype wire

// File: tb/tb_diag_serial_rx.sv
// ============================================================================
//  Module   : tb_diag_serial_rx
//  Purpose  : Directed self-checking bench for diag_serial_rx.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_diag_serial_rx;

   logic       CLK = 1'b0;
   logic       rst = 1'b1;
   logic       sck = 1'b0;
   logic       cs_n = 1'b1;
   logic       sdi = 1'b0;
   logic       m_ready = 1'b0;
   logic       ovf_clr = 1'b0;
   logic [7:0] m_data;
   logic       m_first;
   logic       m_valid;
   logic       frame_err;
   logic       ovf;
`ifdef DIAG_SERIAL_RX_FRMCNT_EN
   logic [7:0] frame_len;
   logic       frame_done;
`endif

   int         n_vec = 0;
   int         n_err = 0;
   int         err_pulses = 0;
   int         done_pulses = 0;
   logic [8:0] rx_q[$];

   diag_serial_rx #(.FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
      .CLK       (CLK),
      .rst       (rst),
      .sck       (sck),
      .cs_n      (cs_n),
      .sdi       (sdi),
      .m_data    (m_data),
      .m_first   (m_first),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .frame_err (frame_err),
      .ovf       (ovf),
      .ovf_clr   (ovf_clr)
`ifdef DIAG_SERIAL_RX_FRMCNT_EN
     ,.frame_len (frame_len),
      .frame_done(frame_done)
`endif
   );

   always #5 CLK = ~CLK;

   // Record every accepted byte and count pulse outputs.
   always @(posedge CLK) begin
      if (m_valid && m_ready) rx_q.push_back({m_first, m_data});
      if (frame_err) err_pulses++;
`ifdef DIAG_SERIAL_RX_FRMCNT_EN
      if (frame_done) done_pulses++;
`endif
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- stimulus helpers (no checking) ----------------
   // Lower sck with new data, hold 4 cycles, raise sck at a falling CLK edge.
   task automatic sck_rise_bit(input logic d);
      @(negedge CLK); sck = 1'b0; sdi = d;
      repeat (4) @(negedge CLK);
      sck = 1'b1;
   endtask

   task automatic send_bits(input logic [7:0] b, input int n);
      for (int i = 0; i < n; i++) begin
         sck_rise_bit(b[7-i]);
         repeat (4) @(negedge CLK);
      end
   endtask

   // Sends a byte and returns 1 ns after the first CLK edge that sees the 8th sck rise.
   task automatic send_byte_to_e1(input logic [7:0] b);
      send_bits(b, 7);
      sck_rise_bit(b[0]);
      @(posedge CLK); #1;
   endtask

   task automatic frame_start();
      @(negedge CLK); sck = 1'b0; cs_n = 1'b0;
      repeat (6) @(negedge CLK);
   endtask

   task automatic frame_end();
      @(negedge CLK); sck = 1'b0;
      repeat (4) @(negedge CLK);
      cs_n = 1'b1;
      repeat (8) @(negedge CLK);
   endtask

   task automatic drain(input int n);
      @(negedge CLK); m_ready = 1'b1;
      repeat (n) @(negedge CLK);
      m_ready = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      repeat (3) @(negedge CLK);
      n_vec++;
      if ({m_valid, m_first, m_data, frame_err, ovf} !== 12'h000) begin
         n_err++; $display("FAIL reset_hold: got %h expected 000", {m_valid, m_first, m_data, frame_err, ovf});
      end
      rst = 1'b0;
      repeat (6) @(negedge CLK);
      n_vec++;
      if ({m_valid, m_first, m_data, frame_err, ovf} !== 12'h000) begin
         n_err++; $display("FAIL reset_release: got %h expected 000", {m_valid, m_first, m_data, frame_err, ovf});
      end
   endtask

   task automatic test_single_byte();
      int e0;
      e0 = err_pulses;
      rx_q.delete();
      frame_start();
      send_byte_to_e1(8'hA5);
      @(posedge CLK); @(posedge CLK); #1;
      n_vec++;
      if (m_valid !== 1'b0) begin
         n_err++; $display("FAIL latency_early: m_valid got %b expected 0", m_valid);
      end
      @(posedge CLK); #1;
      n_vec++;
      if ({m_valid, m_first, m_data} !== {1'b1, 1'b1, 8'hA5}) begin
         n_err++; $display("FAIL single_byte: got v=%b f=%b d=%h expected v=1 f=1 d=a5", m_valid, m_first, m_data);
      end
      repeat (10) @(negedge CLK);
      n_vec++;
      if ({m_valid, m_first, m_data} !== {1'b1, 1'b1, 8'hA5}) begin
         n_err++; $display("FAIL head_stable: got v=%b f=%b d=%h expected v=1 f=1 d=a5", m_valid, m_first, m_data);
      end
      frame_end();
      n_vec++;
      if (err_pulses - e0 !== 0) begin
         n_err++; $display("FAIL single_no_err: frame_err pulses got %0d expected 0", err_pulses - e0);
      end
      drain(4);
      n_vec++;
      if (rx_q.size() !== 1 || m_valid !== 1'b0) begin
         n_err++; $display("FAIL single_drain: got %0d bytes valid=%b expected 1 byte valid=0", rx_q.size(), m_valid);
      end
   endtask

   task automatic test_multi_byte();
      logic [8:0] exp_q[3];
      exp_q[0] = 9'h112; exp_q[1] = 9'h034; exp_q[2] = 9'h056;
      rx_q.delete();
      @(negedge CLK); m_ready = 1'b1;
      frame_start();
      send_bits(8'h12, 8);
      send_bits(8'h34, 8);
      send_bits(8'h56, 8);
      frame_end();
      m_ready = 1'b0;
      n_vec++;
      if (rx_q.size() !== 3) begin
         n_err++; $display("FAIL multi_count: got %0d bytes expected 3", rx_q.size());
      end
      for (int i = 0; i < 3; i++) begin
         n_vec++;
         if (rx_q.size() <= i || rx_q[i] !== exp_q[i]) begin
            n_err++; $display("FAIL multi_byte%0d: got %h expected %h", i, (rx_q.size() > i) ? rx_q[i] : 9'h1ff, exp_q[i]);
         end
      end
   endtask

   task automatic test_partial();
      int e0;
      e0 = err_pulses;
      rx_q.delete();
      frame_start();
      send_bits(8'h3C, 8);
      send_bits(8'b1010_1000, 5);
      frame_end();
      n_vec++;
      if (err_pulses - e0 !== 1) begin
         n_err++; $display("FAIL partial_err: frame_err pulses got %0d expected 1", err_pulses - e0);
      end
      drain(6);
      n_vec++;
      if (rx_q.size() !== 1 || rx_q[0] !== 9'h13C) begin
         n_err++; $display("FAIL partial_byte: got %0d bytes head %h expected 1 byte 13c", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 9'h1ff);
      end
      frame_start();
      send_bits(8'hC3, 8);
      frame_end();
      drain(6);
      n_vec++;
      if (rx_q.size() !== 2 || rx_q[1] !== 9'h1C3) begin
         n_err++; $display("FAIL realign: got %0d bytes last %h expected 2 bytes last 1c3", rx_q.size(), (rx_q.size() > 1) ? rx_q[1] : 9'h1ff);
      end
      n_vec++;
      if (err_pulses - e0 !== 1) begin
         n_err++; $display("FAIL realign_err: frame_err pulses got %0d expected 1", err_pulses - e0);
      end
   endtask

   task automatic test_overflow();
      logic [8:0] exp_q[5];
      exp_q[0] = 9'h101; exp_q[1] = 9'h002; exp_q[2] = 9'h003; exp_q[3] = 9'h004; exp_q[4] = 9'h006;
      rx_q.delete();
      m_ready = 1'b0;
      frame_start();
      for (int k = 1; k <= 5; k++) send_bits(8'(k), 8);
      repeat (4) @(negedge CLK);
      n_vec++;
      if (ovf !== 1'b1) begin
         n_err++; $display("FAIL ovf_set: got %b expected 1", ovf);
      end
      n_vec++;
      if ({m_first, m_data} !== 9'h101) begin
         n_err++; $display("FAIL ovf_head: got %h expected 101", {m_first, m_data});
      end
      ovf_clr = 1'b1;
      @(negedge CLK); ovf_clr = 1'b0;
      n_vec++;
      if (ovf !== 1'b0) begin
         n_err++; $display("FAIL ovf_clr: got %b expected 0", ovf);
      end
      // Pop exactly on the cycle the sixth byte is written into the full FIFO.
      send_byte_to_e1(8'h06);
      @(posedge CLK); @(posedge CLK); #1;
      m_ready = 1'b1;
      @(posedge CLK); #1;
      m_ready = 1'b0;
      n_vec++;
      if (ovf !== 1'b0) begin
         n_err++; $display("FAIL pushpop_full_ovf: got %b expected 0", ovf);
      end
      n_vec++;
      if ({m_valid, m_first, m_data} !== 10'h202) begin
         n_err++; $display("FAIL pushpop_head: got %h expected 202", {m_valid, m_first, m_data});
      end
      repeat (4) @(negedge CLK);
      frame_end();
      drain(8);
      n_vec++;
      if (rx_q.size() !== 5) begin
         n_err++; $display("FAIL ovf_count: got %0d bytes expected 5", rx_q.size());
      end
      for (int i = 0; i < 5; i++) begin
         n_vec++;
         if (rx_q.size() <= i || rx_q[i] !== exp_q[i]) begin
            n_err++; $display("FAIL ovf_byte%0d: got %h expected %h", i, (rx_q.size() > i) ? rx_q[i] : 9'h1ff, exp_q[i]);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      int e0;
      rx_q.delete();
      m_ready = 1'b0;
      frame_start();
      send_bits(8'h5A, 8);
      send_bits(8'hB0, 4);
      @(negedge CLK); #2 rst = 1'b1;
      #1;
      n_vec++;
      if ({m_valid, m_first, m_data, frame_err, ovf} !== 12'h000) begin
         n_err++; $display("FAIL midframe_reset: got %h expected 000", {m_valid, m_first, m_data, frame_err, ovf});
      end
      repeat (2) @(negedge CLK);
      rst = 1'b0;
      e0 = err_pulses;
      // Remaining bits of the interrupted frame must be ignored.
      send_bits(8'h0F, 4);
      send_bits(8'h99, 8);
      n_vec++;
      if (m_valid !== 1'b0) begin
         n_err++; $display("FAIL midframe_ignored: m_valid got %b expected 0", m_valid);
      end
      frame_end();
      n_vec++;
      if (err_pulses - e0 !== 0) begin
         n_err++; $display("FAIL midframe_err: frame_err pulses got %0d expected 0", err_pulses - e0);
      end
      frame_start();
      send_bits(8'hFF, 8);
      frame_end();
      drain(6);
      n_vec++;
      if (rx_q.size() !== 1 || rx_q[0] !== 9'h1FF) begin
         n_err++; $display("FAIL after_reset_byte: got %0d bytes head %h expected 1 byte 1ff", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 9'h000);
      end
   endtask

`ifdef DIAG_SERIAL_RX_FRMCNT_EN
   task automatic test_frame_count();
      int d0;
      d0 = done_pulses;
      @(negedge CLK); m_ready = 1'b1;
      frame_start();
      send_bits(8'h11, 8);
      send_bits(8'h22, 8);
      send_bits(8'h33, 8);
      frame_end();
      m_ready = 1'b0;
      n_vec++;
      if (frame_len !== 8'd3) begin
         n_err++; $display("FAIL frame_len: got %0d expected 3", frame_len);
      end
      n_vec++;
      if (done_pulses - d0 !== 1) begin
         n_err++; $display("FAIL frame_done: pulses got %0d expected 1", done_pulses - d0);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single_byte();
      test_multi_byte();
      test_partial();
      test_overflow();
      test_reset_mid_frame();
`ifdef DIAG_SERIAL_RX_FRMCNT_EN
      test_frame_count();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
